aes_inv_key_sched: RTL

- Reverse-direction AES-128 key schedule. The forward round-key block steps a key from round 0 to round 10; this block takes the final (round 10) key and regenerates round keys 10, 9, …, 0 in descending order, one round per accepted handshake.
- Feeds the decryption datapath. That datapath consumes round keys last-to-first, so no 11×128-bit key store is needed.
- Exposes the Rcon byte of the step it is undoing, for debug and for checking against the forward block.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_inv_key_sched_if.sv | 26 ++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_inv_key_sched.sv | 136 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, backward-walk Rcon seed,
// key-schedule FSM states and word/byte slice helpers for the w0..w3 layout.
package aes_pkg;

   localparam int         NR_AES128 = 10;
   localparam logic [7:0] RCON_LAST = 8'h36;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } ks_state_e;

   // Forward AES S-box, indexed by the input byte.
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Word n of a 128-bit key; w0 occupies bits [127:96].
   function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] n);
      logic [31:0] w;
      case (n)
         2'd0:    w = key[127:96];
         2'd1:    w = key[95:64];
         2'd2:    w = key[63:32];
         2'd3:    w = key[31:0];
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   // Byte n of a word; byte 0 is the most significant.
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] n);
      logic [7:0] b;
      case (n)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         2'd3:    b = w[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // RotWord({a,b,c,d}) = {b,c,d,a}.
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle between the reverse key schedule and its consumer.
interface aes_inv_key_sched_if;

   logic         start;
   logic [127:0] key_last;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic [7:0]   Rcon_out;
   logic         round_key_valid;
   logic         round_key_ready;
   logic         busy;
   logic         done;

   // Consumer side: requests a walk and accepts keys.
   modport master (
      output start, key_last, round_key_ready,
      input  round_key, round_idx, Rcon_out, round_key_valid, busy, done
   );

   // Key-schedule side: produces round keys.
   modport slave (
      input  start, key_last, round_key_ready,
      output round_key, round_idx, Rcon_out, round_key_valid, busy, done
   );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box; shared with the forward key schedule.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: loads the round-NR key and walks back to
// round 0, presenting one round key per accepted valid/ready handshake.
module aes_inv_key_sched #(
   parameter int         NR        = 10,
   parameter logic [7:0] RCON_LAST = aes_pkg::RCON_LAST
) (
   input  logic               clock,
   input  logic               reset_n,
   aes_inv_key_sched_if.slave bus
);
   import aes_pkg::*;

   if (NR != NR_AES128) begin : g_nr_check
      $error("aes_inv_key_sched supports only NR = 10 (AES-128)");
   end

   ks_state_e    state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   idx_q, idx_d;
   logic [7:0]   rcon_q, rcon_d;
   logic         valid_q, valid_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [31:0]  w0_s, w1_s, w2_s, w3_s;
   logic [31:0]  p0_s, p1_s, p2_s, p3_s;
   logic [31:0]  rot_s, sub_s;
   logic [127:0] prev_key_s;
   logic         xfer_s;

   assign w0_s = key_word(key_q, 2'd0);
   assign w1_s = key_word(key_q, 2'd1);
   assign w2_s = key_word(key_q, 2'd2);
   assign w3_s = key_word(key_q, 2'd3);

   // Undo the XOR chain first; p3 is the word the forward step fed to SubWord.
   assign p3_s  = w3_s ^ w2_s;
   assign p2_s  = w2_s ^ w1_s;
   assign p1_s  = w1_s ^ w0_s;
   assign rot_s = rot_word(p3_s);

   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
         .in_i  (word_byte(rot_s, 2'(g))),
         .out_o (sub_s[31-8*g -: 8])
      );
   end

   assign p0_s       = w0_s ^ sub_s ^ {rcon_q, 24'h00_0000};
   assign prev_key_s = {p0_s, p1_s, p2_s, p3_s};
   assign xfer_s     = valid_q & bus.round_key_ready;

   // Next-state and next-output logic of the walk FSM.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      rcon_d  = rcon_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               key_d   = bus.key_last;
               idx_d   = 4'(NR);
               rcon_d  = RCON_LAST;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = EMIT;
            end else begin
               state_d = IDLE;
            end
         end
         EMIT: begin
            if (xfer_s) begin
               if (idx_q != 4'd0) begin
                  key_d = prev_key_s;
                  idx_d = idx_q - 4'd1;
                  if (idx_q == 4'd1) begin
                     rcon_d = 8'h00;
                  end else if (rcon_q == 8'h1b) begin
                     rcon_d = 8'h80;
                  end else begin
                     rcon_d = {1'b0, rcon_q[7:1]};
                  end
               end else begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end else begin
               state_d = EMIT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any walk in progress.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         key_q   <= 128'h0;
         idx_q   <= 4'd0;
         rcon_q  <= 8'h00;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         rcon_q  <= rcon_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.round_key       = key_q;
   assign bus.round_idx       = idx_q;
   assign bus.Rcon_out        = rcon_q;
   assign bus.round_key_valid = valid_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;

endmodule
